// File: rtl/fp32_invsqrt_prep.sv
// fp32_invsqrt_prep: resolves special fp32 operands and presents normalised significand,
// exponent, seed-LUT address and halved exponent to the inverse-square-root core.
module fp32_invsqrt_prep (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_special,
    output logic [31:0] out_special_val,
    output logic [23:0] out_mant,
    output logic [9:0]  out_exp_b,
    output logic [7:0]  out_lut_addr,
    output logic [7:0]  out_exp_half
);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_NORM = 1'b1;

    logic        r_state;
    logic [23:0] r_sig;
    logic [9:0]  r_exp;
    logic        r_valid;
    logic        r_special;
    logic [31:0] r_sval;
    logic [23:0] r_mant;
    logic [9:0]  r_exp_b;
    logic [7:0]  r_lut;
    logic [7:0]  r_half;

    logic [7:0]  w_e;
    logic [22:0] w_m;
    logic        w_nan;
    logic        w_spec;
    logic [31:0] w_sval;
    logic        w_sub;
    logic        w_acc;
    logic [3:0]  w_top;
    logic [1:0]  w_lz;
    logic        w_done;
    logic        w_load;
    logic        w_ld_spec;
    logic [23:0] w_ld_mant;
    logic [9:0]  w_ld_exp;
    logic [7:0]  w_ld_half;

    assign w_e       = fp_in[30:23];
    assign w_m       = fp_in[22:0];
    assign w_nan     = (w_e == 8'hFF && w_m != 23'd0) || (fp_in[31] && fp_in[30:0] != 31'd0);
    assign w_spec    = fp_in[31] || w_e == 8'hFF || fp_in[30:0] == 31'd0;
    assign w_sval    = w_nan ? 32'h7FC00001 : (w_e == 8'hFF ? 32'h0 : 32'h7F800000);
    assign w_sub     = !w_spec && w_e == 8'd0;
    assign in_ready  = rst_n && r_state != S_NORM && (!r_valid || out_ready);
    assign w_acc     = in_valid && in_ready;

    // Final normalisation step: at most 3 more bits once a one sits in the top nibble
    assign w_top     = r_sig[23:20];
    assign w_lz      = w_top[3] ? 2'd0 : w_top[2] ? 2'd1 : w_top[1] ? 2'd2 : 2'd3;
    assign w_done    = r_state == S_NORM && w_top != 4'd0;
    assign w_load    = w_done || (w_acc && !w_sub);
    assign w_ld_spec = !w_done && w_spec;
    assign w_ld_mant = w_done ? r_sig << w_lz : w_spec ? 24'd0 : {1'b1, w_m};
    assign w_ld_exp  = w_done ? r_exp - {8'd0, w_lz} : w_spec ? 10'd0 : {2'b00, w_e};
    assign w_ld_half = w_ld_spec ? 8'd0 : 8'((10'sd381 - $signed(w_ld_exp)) >>> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sig     <= 24'd0;
            r_exp     <= 10'd0;
            r_valid   <= 1'b0;
            r_special <= 1'b0;
            r_sval    <= 32'd0;
            r_mant    <= 24'd0;
            r_exp_b   <= 10'd0;
            r_lut     <= 8'd0;
            r_half    <= 8'd0;
        end else begin
            if (w_acc && w_sub) begin
                r_state <= S_NORM;
                r_sig   <= {1'b0, w_m};
                r_exp   <= 10'd1;
            end else if (r_state == S_NORM) begin
                if (w_top == 4'd0) begin
                    r_sig <= r_sig << 4;
                    r_exp <= r_exp - 10'd4;
                end else begin
                    r_state <= S_IDLE;
                end
            end
            if (w_load) begin
                r_valid   <= 1'b1;
                r_special <= w_ld_spec;
                r_sval    <= w_ld_spec ? w_sval : 32'd0;
                r_mant    <= w_ld_mant;
                r_exp_b   <= w_ld_exp;
                r_lut     <= w_ld_spec ? 8'd0 : {w_ld_exp[0], w_ld_mant[22:16]};
                r_half    <= w_ld_half;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid       = r_valid;
    assign out_special     = r_special;
    assign out_special_val = r_sval;
    assign out_mant        = r_mant;
    assign out_exp_b       = r_exp_b;
    assign out_lut_addr    = r_lut;
    assign out_exp_half    = r_half;
endmodule

// File: tb/tb_fp32_invsqrt_prep.sv
// tb_fp32_invsqrt_prep: directed table, random operands against a value-level model,
// plus throughput, backpressure and mid-normalisation reset sequences.
module tb_fp32_invsqrt_prep;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic        out_special;
    logic [31:0] out_special_val;
    logic [23:0] out_mant;
    logic [9:0]  out_exp_b;
    logic [7:0]  out_lut_addr;
    logic [7:0]  out_exp_half;

    int total = 0;
    int bad = 0;

    fp32_invsqrt_prep dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .fp_in(fp_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
        .out_special_val(out_special_val), .out_mant(out_mant), .out_exp_b(out_exp_b),
        .out_lut_addr(out_lut_addr), .out_exp_half(out_exp_half)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fp;
        logic        sp;
        logic [31:0] sv;
        logic [23:0] m;
        logic [9:0]  eb;
        logic [7:0]  lut;
        logic [7:0]  half;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Value-level reference: classify, then shift the significand until it reaches [2^23, 2^24)
    task automatic model(input logic [31:0] v, output logic sp, output logic [31:0] sv,
                         output logic [23:0] m, output logic [9:0] eb, output logic [7:0] lut,
                         output logic [7:0] half, output int lat);
        int e, f, sig, ebi, lz, hv;
        e = int'(v[30:23]);
        f = int'(v[22:0]);
        sp = 1'b1; sv = 32'd0; m = 24'd0; eb = 10'd0; lut = 8'd0; half = 8'd0; lat = 1;
        if ((e == 255 && f != 0) || (v[31] && v[30:0] != 31'd0)) sv = 32'h7FC00001;
        else if (e == 255) sv = 32'h0;
        else if (v[30:0] == 31'd0) sv = 32'h7F800000;
        else begin
            sp = 1'b0;
            sig = (e == 0) ? f : f + (1 << 23);
            ebi = (e == 0) ? 1 : e;
            lz = 0;
            while (sig < (1 << 23)) begin
                sig = sig * 2;
                ebi--;
                lz++;
            end
            hv = (381 - ebi) / 2;
            m = sig[23:0];
            eb = ebi[9:0];
            lut = {ebi[0], m[22:16]};
            half = hv[7:0];
            lat = (e == 0) ? lz / 4 + 2 : 1;
        end
    endtask

    // Present one operand, count edges until its result appears and cycles spent with in_ready low
    task automatic run_one(input logic [31:0] v, output int lat, output int nr);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        fp_in = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        nr = 0;
        while (!out_valid && lat < 20) begin
            if (!in_ready) nr++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_model(input logic [31:0] v);
        logic sp; logic [31:0] sv; logic [23:0] m; logic [9:0] eb; logic [7:0] lut, half;
        int lat, elat, nr;
        model(v, sp, sv, m, eb, lut, half, elat);
        run_one(v, lat, nr);
        chk($sformatf("rnd_lat %h", v), lat, elat);
        chk($sformatf("rnd_sp %h", v), out_special, sp);
        chk($sformatf("rnd_sv %h", v), out_special_val, sv);
        chk($sformatf("rnd_mant %h", v), out_mant, m);
        chk($sformatf("rnd_eb %h", v), out_exp_b, eb);
        chk($sformatf("rnd_lut %h", v), out_lut_addr, lut);
        chk($sformatf("rnd_half %h", v), out_exp_half, half);
    endtask

    initial begin
        vec_t tbl[15];
        logic [31:0] spec_in[4];
        logic [31:0] spec_out[4];
        logic [31:0] nv[9];
        logic sp; logic [31:0] sv; logic [23:0] m; logic [9:0] eb; logic [7:0] lut, half;
        logic [22:0] f;
        logic [31:0] v;
        int lat, nr, elat;

        tbl[0]  = '{32'h40800000, 1'b0, 32'h0,        24'h800000, 10'd129,   8'h80, 8'd126, 1};
        tbl[1]  = '{32'h00400000, 1'b0, 32'h0,        24'h800000, 10'd0,     8'h00, 8'd190, 2};
        tbl[2]  = '{32'h00000001, 1'b0, 32'h0,        24'h800000, 10'h3EA,   8'h00, 8'd201, 7};
        tbl[3]  = '{32'h7FC00000, 1'b1, 32'h7FC00001, 24'h0,      10'd0,     8'h00, 8'd0,   1};
        tbl[4]  = '{32'hBF800000, 1'b1, 32'h7FC00001, 24'h0,      10'd0,     8'h00, 8'd0,   1};
        tbl[5]  = '{32'h7F800000, 1'b1, 32'h00000000, 24'h0,      10'd0,     8'h00, 8'd0,   1};
        tbl[6]  = '{32'h80000000, 1'b1, 32'h7F800000, 24'h0,      10'd0,     8'h00, 8'd0,   1};
        tbl[7]  = '{32'h00000000, 1'b1, 32'h7F800000, 24'h0,      10'd0,     8'h00, 8'd0,   1};
        tbl[8]  = '{32'hFF800000, 1'b1, 32'h7FC00001, 24'h0,      10'd0,     8'h00, 8'd0,   1};
        tbl[9]  = '{32'h80000001, 1'b1, 32'h7FC00001, 24'h0,      10'd0,     8'h00, 8'd0,   1};
        tbl[10] = '{32'h3F800000, 1'b0, 32'h0,        24'h800000, 10'd127,   8'h80, 8'd127, 1};
        tbl[11] = '{32'h3FC00000, 1'b0, 32'h0,        24'hC00000, 10'd127,   8'hC0, 8'd127, 1};
        tbl[12] = '{32'h00800000, 1'b0, 32'h0,        24'h800000, 10'd1,     8'h80, 8'd190, 1};
        tbl[13] = '{32'h7F7FFFFF, 1'b0, 32'h0,        24'hFFFFFF, 10'd254,   8'h7F, 8'd63,  1};
        tbl[14] = '{32'h000FFFFF, 1'b0, 32'h0,        24'hFFFFF0, 10'h3FD,   8'hFF, 8'd192, 3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fp_in = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mant", out_mant, 0);
        chk("rst_sval", out_special_val, 0);
        chk("rst_half", out_exp_half, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 15; i++) begin
            run_one(tbl[i].fp, lat, nr);
            chk($sformatf("t%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("t%0d_busy", i), nr, tbl[i].lat - 1);
            chk($sformatf("t%0d_sp", i), out_special, tbl[i].sp);
            chk($sformatf("t%0d_sv", i), out_special_val, tbl[i].sv);
            chk($sformatf("t%0d_mant", i), out_mant, tbl[i].m);
            chk($sformatf("t%0d_eb", i), out_exp_b, tbl[i].eb);
            chk($sformatf("t%0d_lut", i), out_lut_addr, tbl[i].lut);
            chk($sformatf("t%0d_half", i), out_exp_half, tbl[i].half);
        end

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0: v = $urandom();
                1: begin
                    f = 23'($urandom());
                    f = f >> $urandom_range(0, 22);
                    v = {9'd0, f};
                end
                default: v = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom())};
            endcase
            check_model(v);
        end

        spec_in  = '{32'h7FC00000, 32'hBF800000, 32'h7F800000, 32'h80000000};
        spec_out = '{32'h7FC00001, 32'h7FC00001, 32'h00000000, 32'h7F800000};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_ready%0d", i), in_ready, 1);
            fp_in = spec_in[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("b2b_valid%0d", i), out_valid, 1);
            chk($sformatf("b2b_sp%0d", i), out_special, 1);
            chk($sformatf("b2b_sv%0d", i), out_special_val, spec_out[i]);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 9; i++) nv[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom())};
        for (int i = 0; i < 8; i++) begin
            fp_in = nv[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
            model(nv[i], sp, sv, m, eb, lut, half, elat);
            chk($sformatf("str_valid%0d", i), out_valid, 1);
            chk($sformatf("str_mant%0d", i), out_mant, m);
            chk($sformatf("str_eb%0d", i), out_exp_b, eb);
        end
        model(nv[7], sp, sv, m, eb, lut, half, elat);
        fp_in = nv[8];
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready%0d", i), in_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("bp_valid%0d", i), out_valid, 1);
            chk($sformatf("bp_mant%0d", i), out_mant, m);
            chk($sformatf("bp_eb%0d", i), out_exp_b, eb);
            chk($sformatf("bp_half%0d", i), out_exp_half, half);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(nv[8], sp, sv, m, eb, lut, half, elat);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_mant", out_mant, m);
        chk("bp_next_eb", out_exp_b, eb);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 0);

        fp_in = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_ready_low", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mrst_quiet%0d", i), out_valid, 0);
        end
        run_one(32'h3F800000, lat, nr);
        chk("mrst_next_lat", lat, 1);
        chk("mrst_next_eb", out_exp_b, 10'd127);
        chk("mrst_next_mant", out_mant, 24'h800000);
        chk("mrst_next_sp", out_special, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
